bitcell_array_ctrl: RTL and testbench
=====================================

# bitcell_array_ctrl

Sequencing controller that drives the 4x4 bitcell array's word lines, bit lines and compute inputs from a simple command stream. It replaces hand-written stimulus with a synthesizable master. Write commands store a row of data through a timed word-line pulse. Compute commands apply an operand, wait for the array to settle, sample `OUTPUT` and return it on a valid/ready response port. It sits between the host/command logic and `bitcell_array`.

## Interface
- `ROWS`, default 4: word lines / addressable rows.
- `COLS`, default 4: bit lines / output columns.
- `SETUP`, default 1: cycles BL/INPUT/SI/CI are driven before WL rises or settle starts; must be ≥1.
- `WR_PULSE`, default 2: cycles WL is high per write; must be ≥1.
- `SETTLE`, default 2: cycles waited in compute before `OUTPUT` is sampled; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller accepts a command this cycle.
- `cmd_op` in 1: 0 = write row, 1 = compute.
- `cmd_row` in clog2(ROWS): target row for write; ignored for compute.
- `cmd_data` in COLS: write data, or compute operand driven on BL.
- `cmd_input` in COLS: value for array INPUT (compute only).
- `cmd_si` in COLS: value for array SI (compute only).
- `cmd_ci` in COLS: value for array CI (compute only).
- `rsp_valid` out 1: compute result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_data` out COLS: sampled `OUTPUT`.
- `WL` out ROWS: word lines to array.
- `BL` out COLS: bit lines to array.
- `INPUT`, `SI`, `CI` out COLS each: to array.
- `OUTPUT` in COLS: from array.

## Operation
- States: IDLE, SETUP, PULSE (write), HOLD (write), SETTLE (compute), RESP (compute).
- A command is accepted on an edge where `cmd_valid && cmd_ready`. All command fields are registered at acceptance.
- `cmd_ready` = (state == IDLE); it is combinational from registered state.
- Write path:
  - IDLE → SETUP (SETUP cycles): BL=data, WL=0, INPUT/SI/CI=0.
  - → PULSE (WR_PULSE cycles): WL = one-hot(row), BL held.
  - → HOLD (1 cycle): WL=0, BL held.
  - → IDLE. No response is produced.
- Compute path:
  - IDLE → SETUP (SETUP cycles): BL=data, INPUT/SI/CI from command, WL=0.
  - → SETTLE (SETTLE cycles). On the final SETTLE edge, capture `OUTPUT` into `rsp_data`.
  - → RESP: `rsp_valid`=1, drives held.
  - Leave RESP on `rsp_ready`, then → IDLE.
- WL is one-hot or zero at all times. It is never high outside PULSE. It never changes in the same cycle as BL.
- `cmd_row` ≥ ROWS: the write runs its full timing with WL=0 throughout (no row written).
- In IDLE, BL/INPUT/SI/CI retain their last driven values; WL=0.
- Phase timing uses one down-counter, width clog2(max(SETUP,WR_PULSE,SETTLE)+1), reloaded on each state entry.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=IDLE; WL, BL, INPUT, SI, CI, rsp_data = 0.
  - rsp_valid=0; cmd_ready=1 after reset deasserts.
- Write, accepted at edge T:
  - WL high during cycles T+SETUP+1 .. T+SETUP+WR_PULSE.
  - `cmd_ready` high again at cycle T+SETUP+WR_PULSE+2 (T+5 with defaults).
- Compute, accepted at edge T:
  - `OUTPUT` sampled at edge T+SETUP+SETTLE.
  - `rsp_valid` high from cycle T+SETUP+SETTLE+1 (T+4 with defaults).
  - `rsp_data` and `rsp_valid` are stable until the `rsp_ready` handshake edge.
- `rsp_ready` already high on entry to RESP: the handshake occurs in that first RESP cycle; IDLE follows next cycle.
- Throughput: one command per (busy cycles + 1). No pipelining of commands.
- Reset mid-operation: WL drops to 0 immediately (asynchronously). Any pending response is discarded.

## Structure
- Shared package `bitcell_pkg`:
  - state enum;
  - `OP_WRITE`/`OP_COMPUTE` constants;
  - default ROWS/COLS.
- Sub-module `bitcell_wl_decoder`: row index + enable → one-hot WL, zero when out of range.
- Everything else lives in `bitcell_array_ctrl`.

## Test plan
- Write row 0 with 4'b0110:
  - WL=4'b0001 for exactly 2 cycles;
  - BL=4'b0110 stable from one cycle before WL rise to one cycle after WL fall;
  - next command accepted at T+5.
- Write row 1 with 4'b1101 back-to-back after row 0 (cmd_valid held high):
  - WL never overlaps between rows;
  - WL=4'b0000 for at least 2 cycles between pulses.
- After the writes above, compute sweep of all 16 BL operands (INPUT/SI/CI=0) against an instantiated `bitcell_array`:
  - each `rsp_data` equals array `OUTPUT` at the sample edge;
  - 16 responses in order.
- Compute with `rsp_ready` low for 5 cycles:
  - `rsp_valid`/`rsp_data` held;
  - `cmd_ready`=0 throughout;
  - single response on release.
- Write with cmd_row=3 and ROWS=3:
  - full timing observed;
  - WL stays 4'b0000;
  - no response.
- Assert `rst` during PULSE:
  - WL=0 and all drives 0 without a clock edge;
  - `cmd_ready`=1 on the first cycle after release.

Source files
------------

// File: rtl/bitcell_pkg.sv
// bitcell_pkg: shared states, opcodes and default geometry for the bitcell array controller.
package bitcell_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_SETTLE, S_RESP} state_t;
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_COMPUTE = 1'b1;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
endpackage

// File: rtl/bitcell_wl_decoder.sv
// bitcell_wl_decoder: row index to one-hot word lines, all zero when disabled or out of range.
module bitcell_wl_decoder
    import bitcell_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int RW = 2
) (
    input  logic [RW-1:0]   row,
    input  logic            en,
    output logic [ROWS-1:0] wl
);
    for (genvar i = 0; i < ROWS; i++) begin : g_wl
        assign wl[i] = en && (32'(row) == i);
    end
endmodule

// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl: sequences timed word-line writes and settle/sample compute
// operations on the bitcell array from a valid/ready command stream.
module bitcell_array_ctrl
    import bitcell_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int SETTLE = 2,
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [RW-1:0]   cmd_row,
    input  logic [COLS-1:0] cmd_data,
    input  logic [COLS-1:0] cmd_input,
    input  logic [COLS-1:0] cmd_si,
    input  logic [COLS-1:0] cmd_ci,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_data,
    output logic [ROWS-1:0] WL,
    output logic [COLS-1:0] BL,
    output logic [COLS-1:0] INPUT,
    output logic [COLS-1:0] SI,
    output logic [COLS-1:0] CI,
    input  logic [COLS-1:0] OUTPUT
);
    localparam int MX = SETUP > WR_PULSE ? (SETUP > SETTLE ? SETUP : SETTLE)
                                         : (WR_PULSE > SETTLE ? WR_PULSE : SETTLE);
    localparam int CW = $clog2(MX + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            op;
    logic [RW-1:0]   row;
    logic [ROWS-1:0] dec_wl;

    bitcell_wl_decoder #(.ROWS(ROWS), .RW(RW)) u_dec (
        .row(row),
        .en (op == OP_WRITE),
        .wl (dec_wl)
    );

    assign cmd_ready = state == S_IDLE;

    // WL is only loaded on PULSE entry and cleared on its exit, so it can never move with BL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            op <= OP_WRITE;
            row <= '0;
            WL <= '0;
            BL <= '0;
            INPUT <= '0;
            SI <= '0;
            CI <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    state <= S_SETUP;
                    cnt <= CW'(SETUP - 1);
                    op <= cmd_op;
                    row <= cmd_row;
                    BL <= cmd_data;
                    INPUT <= cmd_op == OP_COMPUTE ? cmd_input : '0;
                    SI <= cmd_op == OP_COMPUTE ? cmd_si : '0;
                    CI <= cmd_op == OP_COMPUTE ? cmd_ci : '0;
                end
                S_SETUP: if (cnt == '0) begin
                    state <= op == OP_WRITE ? S_PULSE : S_SETTLE;
                    cnt <= op == OP_WRITE ? CW'(WR_PULSE - 1) : CW'(SETTLE - 1);
                    WL <= dec_wl;
                end else cnt <= cnt - 1'b1;
                S_PULSE: if (cnt == '0) begin
                    state <= S_HOLD;
                    WL <= '0;
                end else cnt <= cnt - 1'b1;
                S_HOLD: state <= S_IDLE;
                S_SETTLE: if (cnt == '0) begin
                    state <= S_RESP;
                    rsp_data <= OUTPUT;
                    rsp_valid <= 1'b1;
                end else cnt <= cnt - 1'b1;
                S_RESP: if (rsp_ready) begin
                    state <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb_bitcell_array_ctrl: drives the controller against a stub array and checks every
// cycle against a cycle-offset model of the command timing.
module tb_bitcell_array_ctrl;
    import bitcell_pkg::*;
    localparam int S = 1, W = 2, ST = 2;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic cmd_valid = 0, cv3 = 0, cmd_op = 0, rsp_ready = 1, rand_rr = 0;
    logic [1:0] cmd_row = 0;
    logic [3:0] cmd_data = 0, cmd_input = 0, cmd_si = 0, cmd_ci = 0;
    logic cmd_ready, rsp_valid, rdy3, rv3;
    logic [3:0] rsp_data, WL, BL, INPUT, SI, CI, OUTPUT, rd3, bl3, in3, si3, ci3;
    logic [2:0] wl3;

    bitcell_array_ctrl #(.ROWS(4), .COLS(4), .SETUP(S), .WR_PULSE(W), .SETTLE(ST)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data), .cmd_input(cmd_input), .cmd_si(cmd_si),
        .cmd_ci(cmd_ci), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .WL(WL), .BL(BL), .INPUT(INPUT), .SI(SI), .CI(CI), .OUTPUT(OUTPUT)
    );

    bitcell_array_ctrl #(.ROWS(3), .COLS(4), .SETUP(S), .WR_PULSE(W), .SETTLE(ST)) u3 (
        .clk(clk), .rst(rst), .cmd_valid(cv3), .cmd_ready(rdy3), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data), .cmd_input(cmd_input), .cmd_si(cmd_si),
        .cmd_ci(cmd_ci), .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_data(rd3),
        .WL(wl3), .BL(bl3), .INPUT(in3), .SI(si3), .CI(ci3), .OUTPUT(4'b0000)
    );

    // stub array: rows latch BL while their word line is high; output mixes stored rows with drives
    logic [3:0] mem [4];
    always @(posedge clk or posedge rst) begin
        if (rst) for (int r = 0; r < 4; r++) mem[r] <= '0;
        else for (int r = 0; r < 4; r++) if (WL[r]) mem[r] <= BL;
    end
    assign OUTPUT = (BL & (mem[0] ^ mem[1] ^ mem[2] ^ mem[3])) ^ INPUT ^ (SI & CI);

    int errs = 0, checks = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: j counts edges since the accepting edge; outputs follow from the documented offsets
    bit busy = 0, m_op = 0, e_rv = 0;
    int j = 0, m_row = 0;
    logic [3:0] e_bl = 0, e_in = 0, e_si = 0, e_ci = 0, e_rd = 0, e_wl, prev_out = 0, prev_rd = 0;
    logic [3:0] got_q[$], wl_hist[$];

    always @(negedge clk) begin
        if (rst) begin
            busy = 0; j = 0; e_rv = 0;
            e_bl = 0; e_in = 0; e_si = 0; e_ci = 0; e_rd = 0;
            chk("rst_rsp_data", rsp_data, 0);
        end else if (busy) begin
            if (m_op && e_rv && rsp_ready) begin
                busy = 0; e_rv = 0;
                got_q.push_back(prev_rd);
            end else begin
                j++;
                if (!m_op && j == S + W + 1) busy = 0;
                if (m_op && j == S + ST) begin e_rv = 1; e_rd = prev_out; end
            end
        end else if (cmd_valid) begin
            busy = 1; j = 0; m_op = cmd_op; m_row = cmd_row;
            e_bl = cmd_data;
            e_in = cmd_op ? cmd_input : 0;
            e_si = cmd_op ? cmd_si : 0;
            e_ci = cmd_op ? cmd_ci : 0;
        end
        e_wl = (busy && !m_op && j >= S && j <= S + W - 1) ? 4'(1 << m_row) : 4'b0000;
        chk("cmd_ready", cmd_ready, !busy);
        chk("WL", WL, e_wl);
        chk("BL", BL, e_bl);
        chk("INPUT", INPUT, e_in);
        chk("SI", SI, e_si);
        chk("CI", CI, e_ci);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_rv) chk("rsp_data", rsp_data, e_rd);
        prev_out = OUTPUT;
        prev_rd = rsp_data;
        wl_hist.push_back(WL);
    end

    always @(negedge clk) if (rand_rr) begin #2; rsp_ready = 1'($urandom_range(0, 1)); end

    task automatic send(input logic op, input logic [1:0] row, input logic [3:0] d, i, s, c,
                        output int t);
        logic r;
        cmd_valid = 1; cmd_op = op; cmd_row = row; cmd_data = d;
        cmd_input = i; cmd_si = s; cmd_ci = c; t = -1;
        for (int n = 0; n < 100 && t < 0; n++) begin
            r = cmd_ready;
            @(posedge clk);
            if (r) t = int'($time / 10);
            @(negedge clk); #2;
        end
        if (t < 0) chk("send_timeout", 0, 1);
    endtask

    task automatic settle_idle();
        int n;
        cmd_valid = 0;
        for (n = 0; n < 200 && !(cmd_ready && !rsp_valid && !busy); n++) begin
            @(negedge clk); #2;
        end
        if (n == 200) chk("idle_timeout", 0, 1);
        repeat (2) begin @(negedge clk); #2; end
    endtask

    initial begin
        int t0, t1, t, n, n1, n2, last1, first2;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wl", WL, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst = 0;
        @(negedge clk); #2;
        send(OP_WRITE, 0, 4'b0110, 0, 0, 0, t0);
        send(OP_WRITE, 1, 4'b1101, 0, 0, 0, t1);
        chk("b2b_accept_gap", t1 - t0, S + W + 2);
        settle_idle();
        n1 = 0; n2 = 0; last1 = -1; first2 = -1;
        foreach (wl_hist[k]) begin
            if (wl_hist[k] == 4'b0001) begin n1++; last1 = k; end
            if (wl_hist[k] == 4'b0010) begin n2++; if (first2 < 0) first2 = k; end
        end
        chk("wl_row0_cycles", n1, 2);
        chk("wl_row1_cycles", n2, 2);
        chk("wl_gap_ge2", (first2 - last1 - 1) >= 2, 1);

        got_q.delete();
        rsp_ready = 1;
        for (int b = 0; b < 16; b++) send(OP_COMPUTE, 0, 4'(b), 0, 0, 0, t);
        settle_idle();
        chk("sweep_count", got_q.size(), 16);
        foreach (got_q[k]) chk("sweep_data", got_q[k], 4'(k) & 4'b1011);

        got_q.delete();
        rsp_ready = 0;
        send(OP_COMPUTE, 0, 4'b1111, 4'b0011, 4'b0101, 4'b0110, t);
        cmd_valid = 0;
        for (n = 0; n < 20 && !rsp_valid; n++) begin @(negedge clk); #2; end
        chk("stall_rsp_seen", rsp_valid, 1);
        chk("stall_rsp_literal", rsp_data, 4'b1100);
        repeat (5) begin
            @(negedge clk); #2;
            chk("stall_valid_held", rsp_valid, 1);
            chk("stall_data_held", rsp_data, 4'b1100);
            chk("stall_not_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk); #2;
        chk("stall_released", rsp_valid, 0);
        repeat (3) begin @(negedge clk); #2; end
        chk("stall_one_rsp", got_q.size(), 1);
        if (got_q.size() > 0) chk("stall_q_data", got_q[0], 4'b1100);

        rand_rr = 1;
        for (int k = 0; k < 40; k++) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom), t);
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 0;
                repeat ($urandom_range(1, 3)) begin @(negedge clk); #2; end
            end
        end
        cmd_valid = 0;
        @(negedge clk);
        rand_rr = 0;
        #3;
        rsp_ready = 1;
        settle_idle();

        send(OP_WRITE, 2, 4'b1001, 0, 0, 0, t);
        cmd_valid = 0;
        for (n = 0; n < 10 && WL == 0; n++) begin @(negedge clk); #2; end
        chk("pulse_seen", WL, 4'b0100);
        #1 rst = 1;
        #1;
        chk("async_rst_wl", WL, 0);
        chk("async_rst_bl", BL, 0);
        chk("async_rst_input", INPUT, 0);
        chk("async_rst_si", SI, 0);
        chk("async_rst_ci", CI, 0);
        chk("async_rst_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        #2 rst = 0;
        @(negedge clk); #2;
        chk("post_rst_ready", cmd_ready, 1);

        cmd_op = OP_WRITE; cmd_row = 3; cmd_data = 4'b1010;
        chk("r3_ready_before", rdy3, 1);
        cv3 = 1;
        @(posedge clk);
        @(negedge clk); #2;
        cv3 = 0;
        for (int k = 1; k <= S + W + 2; k++) begin
            chk("r3_ready", rdy3, k == S + W + 2);
            chk("r3_wl_zero", wl3, 0);
            chk("r3_no_rsp", rv3, 0);
            if (k <= S + W + 1) chk("r3_bl", bl3, 4'b1010);
            @(negedge clk); #2;
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
